mips_arith_unit: RTL and testbench



---
 rtl/mips_arith_unit.sv | 103 ++++++++++
 tb/tb_mips_arith_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips_arith_unit.sv
// mips_arith_unit: EX-stage ALU with flags, IF-stage PC+4 and ID-stage
// branch-target adder; ALU result and flags also registered for next stage.
module mips_arith_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_plus4_d,
   input  logic [WIDTH-1:0] sign_imm,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] alu_result_q,
   output logic             zero_q,
   output logic             overflow_q
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_LUI  = 4'b1011;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] lui_val;
   logic             slt_bit;
   logic             sltu_bit;
   logic             ovf_add;
   logic             ovf_sub;

   assign sum      = a + b;
   assign diff     = a - b;
   assign lui_val  = {{(WIDTH-16){1'b0}}, b[15:0]} << 16;
   assign slt_bit  = $signed(a) < $signed(b);
   assign sltu_bit = a < b;

   // Signed overflow: operand signs vs result sign
   assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
   assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff[WIDTH-1] != a[WIDTH-1]);

   // Operation select; unused codes yield zero
   always_comb begin
      alu_result = '0;
      overflow   = 1'b0;
      case (alu_op)
         OP_AND:  alu_result = a & b;
         OP_OR:   alu_result = a | b;
         OP_ADD: begin
            alu_result = sum;
            overflow   = ovf_add;
         end
         OP_XOR:  alu_result = a ^ b;
         OP_NOR:  alu_result = ~(a | b);
         OP_SLL:  alu_result = b << shamt;
         OP_SUB: begin
            alu_result = diff;
            overflow   = ovf_sub;
         end
         OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_SRL:  alu_result = b >> shamt;
         OP_SRA:  alu_result = $signed(b) >>> shamt;
         OP_LUI:  alu_result = lui_val;
         default: alu_result = '0;
      endcase
   end

   assign zero          = (alu_result == '0);
   assign pc_plus4      = pc + WIDTH'(4);
   assign branch_target = pc_plus4_d + (sign_imm << 2);

   // Pipeline register: reset wins over enable, otherwise load or hold
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_q <= '0;
         zero_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (en) begin
         alu_result_q <= alu_result;
         zero_q       <= zero;
         overflow_q   <= overflow;
      end
   end

endmodule

// File: tb/tb_mips_arith_unit.sv
// tb_mips_arith_unit: directed vectors for ALU, flags, PC adders and
// the output register.
module tb_mips_arith_unit;

   logic        clk;
   logic        reset;
   logic        en;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic [3:0]  alu_op;
   logic [31:0] pc;
   logic [31:0] pc_plus4_d;
   logic [31:0] sign_imm;
   logic [31:0] alu_result;
   logic        zero;
   logic        overflow;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] alu_result_q;
   logic        zero_q;
   logic        overflow_q;

   int n_pass;
   int n_total;

   mips_arith_unit #(.WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .a             (a),
      .b             (b),
      .shamt         (shamt),
      .alu_op        (alu_op),
      .pc            (pc),
      .pc_plus4_d    (pc_plus4_d),
      .sign_imm      (sign_imm),
      .alu_result    (alu_result),
      .zero          (zero),
      .overflow      (overflow),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .alu_result_q  (alu_result_q),
      .zero_q        (zero_q),
      .overflow_q    (overflow_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [4:0] sh);
      alu_op = op;
      a      = va;
      b      = vb;
      shamt  = sh;
      #1;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      reset      = 1'b1;
      en         = 1'b0;
      a          = '0;
      b          = '0;
      shamt      = '0;
      alu_op     = 4'b0000;
      pc         = '0;
      pc_plus4_d = '0;
      sign_imm   = '0;

      @(posedge clk); #1;
      check("rst_q",    alu_result_q,     32'h0);
      check("rst_zq",   {31'b0, zero_q},  32'h0);
      check("rst_ovq",  {31'b0, overflow_q}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      alu(4'b0010, 32'h5, 32'h3, 5'd0);
      check("add",      alu_result, 32'h8);
      check("add_z",    {31'b0, zero}, 32'h0);
      check("add_ov",   {31'b0, overflow}, 32'h0);
      alu(4'b0110, 32'h5, 32'h3, 5'd0);
      check("sub",      alu_result, 32'h2);
      alu(4'b0110, 32'h1234, 32'h1234, 5'd0);
      check("sub_eq",   alu_result, 32'h0);
      check("sub_eq_z", {31'b0, zero}, 32'h1);
      alu(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
      check("add_ovf",  alu_result, 32'h80000000);
      check("add_ovf_f", {31'b0, overflow}, 32'h1);
      alu(4'b0110, 32'h80000000, 32'h1, 5'd0);
      check("sub_ovf",  alu_result, 32'h7FFFFFFF);
      check("sub_ovf_f", {31'b0, overflow}, 32'h1);

      alu(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
      check("and",      alu_result, 32'h00F000F0);
      alu(4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
      check("or",       alu_result, 32'hFFF0FFF0);
      alu(4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
      check("xor",      alu_result, 32'hFF00FF00);
      alu(4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
      check("nor",      alu_result, 32'h000F000F);
      check("nor_ov",   {31'b0, overflow}, 32'h0);

      alu(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
      check("slt",      alu_result, 32'h1);
      alu(4'b1000, 32'hFFFFFFFF, 32'h1, 5'd0);
      check("sltu",     alu_result, 32'h0);
      check("sltu_z",   {31'b0, zero}, 32'h1);

      alu(4'b0101, 32'h0, 32'h80000010, 5'd4);
      check("sll",      alu_result, 32'h00000100);
      alu(4'b1001, 32'h0, 32'h80000010, 5'd4);
      check("srl",      alu_result, 32'h08000001);
      alu(4'b1010, 32'h0, 32'h80000010, 5'd4);
      check("sra",      alu_result, 32'hF8000001);
      alu(4'b1011, 32'h0, 32'h00001234, 5'd0);
      check("lui",      alu_result, 32'h12340000);
      alu(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
      check("op_f",     alu_result, 32'h0);
      check("op_f_z",   {31'b0, zero}, 32'h1);

      pc = 32'h00400000; #1;
      check("pc4",      pc_plus4, 32'h00400004);
      pc = 32'hFFFFFFFC; #1;
      check("pc4_wrap", pc_plus4, 32'h00000000);
      pc_plus4_d = 32'h00400010;
      sign_imm   = 32'h00000003; #1;
      check("bt_fwd",   branch_target, 32'h0040001C);
      sign_imm   = 32'hFFFFFFFE; #1;
      check("bt_back",  branch_target, 32'h00400008);

      @(negedge clk);
      alu(4'b0010, 32'h2, 32'h2, 5'd0);
      en = 1'b1;
      @(posedge clk); #1;
      check("reg_cap",  alu_result_q, 32'h4);
      check("reg_zq",   {31'b0, zero_q}, 32'h0);

      @(negedge clk);
      en = 1'b0;
      alu(4'b0010, 32'h7, 32'h2, 5'd0);
      @(posedge clk); #1;
      check("reg_hold", alu_result_q, 32'h4);
      check("comb_new", alu_result, 32'h9);

      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_q",  alu_result_q, 32'h0);
      check("rst_mid_zq", {31'b0, zero_q}, 32'h0);
      check("rst_comb",   alu_result, 32'h9);

      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("resume_q", alu_result_q, 32'h9);

      @(negedge clk);
      alu(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
      @(posedge clk); #1;
      check("ovq",      {31'b0, overflow_q}, 32'h1);
      check("ovq_res",  alu_result_q, 32'h80000000);

      @(negedge clk);
      alu(4'b0110, 32'h55, 32'h55, 5'd0);
      @(posedge clk); #1;
      check("zq_set",   {31'b0, zero_q}, 32'h1);
      check("ovq_clr",  {31'b0, overflow_q}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
